// File: rtl/mseq_pkg.sv
// mseq_pkg: shared state encoding, address width default and width-to-stride helper for mseq.
package mseq_pkg;
  localparam int MSEQ_ADDR_W = 10;
  typedef enum logic [1:0] {
    MSEQ_IDLE = 2'd0,
    MSEQ_RUN  = 2'd1,
    MSEQ_DONE = 2'd2
  } mseq_state_e;
  function automatic logic [4:0] width_stride(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction
endpackage

// File: rtl/mseq.sv
// mseq: systolic matrix-multiply operand sequencer driving mcount and the operand fetch handshake.
module mseq
  import mseq_pkg::*;
#(
  parameter int ADDR_W = MSEQ_ADDR_W
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              mstart,
  input  logic [ADDR_W-1:0] mbase,
  input  logic              mtxc,
  input  logic [3:0]        mwidth,
  input  logic              count1,
  input  logic              mack,
  output logic              cntld,
  output logic              cnten,
  output logic              mreq,
  output logic [ADDR_W-1:0] maddr,
  output logic              mlast,
  output logic              mdone,
  output logic              busy
);
  mseq_state_e state, state_nxt;
  logic [4:0] stride;
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) state <= MSEQ_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == MSEQ_RUN) ? ((mack && count1) ? MSEQ_DONE : MSEQ_RUN)
                                    : (mstart ? MSEQ_RUN : MSEQ_IDLE);
  // mstart is honoured in IDLE and DONE, which gives back-to-back sequences
  always_comb begin
    cntld = mstart && state != MSEQ_RUN;
    cnten = mack && state == MSEQ_RUN;
    mlast = cnten && count1;
    mdone = state == MSEQ_DONE;
  end
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) begin
      maddr  <= '0;
      stride <= 5'd1;
      mreq   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      mreq <= state_nxt == MSEQ_RUN;
      busy <= state_nxt != MSEQ_IDLE;
      if (cntld) begin
        maddr  <= mbase;
        stride <= mtxc ? width_stride(mwidth) : 5'd1;
      end else if (cnten) begin
        maddr <= maddr + ADDR_W'(stride);
      end
    end
endmodule

// File: tb/tb_mseq.sv
// tb_mseq: directed self-checking bench for mseq with a behavioural mcount alongside.
module tb_mseq;
  logic       clk = 1'b0;
  logic       resetl = 1'b0;
  logic       mstart = 1'b0;
  logic [9:0] mbase = '0;
  logic       mtxc = 1'b0;
  logic [3:0] mwidth = '0;
  logic       count1;
  logic       mack = 1'b0;
  logic       cntld, cnten, mreq, mlast, mdone, busy;
  logic [9:0] maddr;
  logic [3:0] cnt;
  int checks = 0;
  int failures = 0;
  int cnten_sum = 0;

  always #5 clk = ~clk;

  mseq dut (
    .clk(clk), .resetl(resetl), .mstart(mstart), .mbase(mbase), .mtxc(mtxc),
    .mwidth(mwidth), .count1(count1), .mack(mack), .cntld(cntld), .cnten(cnten),
    .mreq(mreq), .maddr(maddr), .mlast(mlast), .mdone(mdone), .busy(busy)
  );

  // mcount: loads mwidth, decrements on enable, no reset
  always @(posedge clk)
    if (cntld) cnt <= mwidth;
    else if (cnten) cnt <= cnt - 4'd1;
  assign count1 = cnt == 4'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic s, input logic a);
    @(posedge clk);
    #1;
    mstart = s;
    mack = a;
    #1;
    cnten_sum += int'(cnten);
  endtask

  task automatic xfer(input string tag, input logic [9:0] a, input logic last);
    tick(1'b0, 1'b1);
    chk({tag, "_mreq"}, 32'(mreq), 32'd1);
    chk({tag, "_maddr"}, 32'(maddr), 32'(a));
    chk({tag, "_mlast"}, 32'(mlast), 32'(last));
  endtask

  task automatic start(input logic [9:0] b, input logic [3:0] w, input logic c);
    @(posedge clk);
    #1;
    mbase = b; mwidth = w; mtxc = c; mstart = 1'b1; mack = 1'b1;
    #1;
    chk("start_cntld", 32'(cntld), 32'd1);
  endtask

  task automatic finish_seq(input string tag);
    tick(1'b0, 1'b0);
    chk({tag, "_mdone"}, 32'(mdone), 32'd1);
    chk({tag, "_mreq_off"}, 32'(mreq), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick(1'b0, 1'b0);
    chk({tag, "_idle_mdone"}, 32'(mdone), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mreq", 32'(mreq), 32'd0);
    chk("rst_maddr", 32'(maddr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mdone", 32'(mdone), 32'd0);
    chk("rst_cntld_cnten", {30'd0, cntld, cnten}, 32'd0);
    resetl = 1'b1;

    start(10'h010, 4'd4, 1'b0);
    chk("row_busy_pre", 32'(busy), 32'd0);
    xfer("row0", 10'h010, 1'b0);
    chk("row0_cnten", 32'(cnten), 32'd1);
    xfer("row1", 10'h011, 1'b0);
    xfer("row2", 10'h012, 1'b0);
    xfer("row3", 10'h013, 1'b1);
    finish_seq("row");

    start(10'h3FE, 4'd3, 1'b1);
    xfer("col0", 10'h3FE, 1'b0);
    xfer("col1", 10'h001, 1'b0);
    xfer("col2", 10'h004, 1'b1);
    finish_seq("col");

    start(10'h000, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) xfer("w16", 10'(i * 16), i == 15);
    finish_seq("w16");

    start(10'h155, 4'd1, 1'b0);
    xfer("w1", 10'h155, 1'b1);
    finish_seq("w1");

    start(10'h100, 4'd3, 1'b0);
    cnten_sum = 0;
    xfer("st0", 10'h100, 1'b0);
    tick(1'b0, 1'b0);
    chk("st1_maddr", 32'(maddr), 32'h101);
    chk("st1_mreq", 32'(mreq), 32'd1);
    chk("st1_cnt", 32'(cnt), 32'd2);
    tick(1'b0, 1'b0);
    chk("st2_maddr", 32'(maddr), 32'h101);
    chk("st2_cnt", 32'(cnt), 32'd2);
    xfer("st3", 10'h101, 1'b0);
    tick(1'b0, 1'b0);
    chk("st4_maddr", 32'(maddr), 32'h102);
    chk("st4_cnt", 32'(cnt), 32'd1);
    chk("st4_mdone", 32'(mdone), 32'd0);
    xfer("st5", 10'h102, 1'b1);
    chk("st_cnten_pulses", 32'(cnten_sum), 32'd3);
    finish_seq("st");

    start(10'h020, 4'd4, 1'b0);
    xfer("arb0", 10'h020, 1'b0);
    tick(1'b1, 1'b1);
    chk("arb_run_cntld", 32'(cntld), 32'd0);
    chk("arb_run_cnt", 32'(cnt), 32'd3);
    chk("arb_run_maddr", 32'(maddr), 32'h021);
    xfer("arb2", 10'h022, 1'b0);
    xfer("arb3", 10'h023, 1'b1);
    @(posedge clk);
    #1;
    mbase = 10'h030; mwidth = 4'd2; mtxc = 1'b0; mstart = 1'b1; mack = 1'b1;
    #1;
    chk("arb_done_mdone", 32'(mdone), 32'd1);
    chk("arb_done_cntld", 32'(cntld), 32'd1);
    xfer("arb_b0", 10'h030, 1'b0);
    chk("arb_b0_mdone", 32'(mdone), 32'd0);
    xfer("arb_b1", 10'h031, 1'b1);
    finish_seq("arb_b");

    start(10'h040, 4'd5, 1'b0);
    xfer("rs0", 10'h040, 1'b0);
    xfer("rs1", 10'h041, 1'b0);
    xfer("rs2", 10'h042, 1'b0);
    resetl = 1'b0;
    #1;
    chk("rs_mreq", 32'(mreq), 32'd0);
    chk("rs_maddr", 32'(maddr), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_cnten", 32'(cnten), 32'd0);
    chk("rs_mlast_mdone", {30'd0, mlast, mdone}, 32'd0);
    tick(1'b0, 1'b0);
    resetl = 1'b1;
    tick(1'b0, 1'b0);
    chk("rs_post_mdone", 32'(mdone), 32'd0);
    chk("rs_post_mreq", 32'(mreq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
